mem_port_arb: RTL and testbench

Round-robin arbiter that shares one port of the dual-port 24-bit data memory among NREQ requesters, for example LSU, DMA and debug.
- Issues at most one memory command per cycle.
- Tracks the 1-cycle read latency and returns a per-requester read-valid.
- Supports a lock so one requester can hold the port for atomic read-modify-write sequences.

---
 rtl/mem_port_arb.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one port of the 24-bit data memory among NREQ requesters, with
// lock support. Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
`ifndef HBIT_ADDR
`define HBIT_ADDR 11
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

module mem_port_arb #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic                iw_req       [0:NREQ-1],
    input  logic                iw_we        [0:NREQ-1],
    input  logic                iw_lock      [0:NREQ-1],
    input  logic [`HBIT_ADDR:0] iw_addr      [0:NREQ-1],
    input  logic [`HBIT_DATA:0] iw_wdata     [0:NREQ-1],
    output logic                ow_gnt       [0:NREQ-1],
    output logic                or_rvalid    [0:NREQ-1],
    output logic [`HBIT_DATA:0] ow_rdata,
    output logic                ow_mem_we,
    output logic [`HBIT_ADDR:0] ow_mem_addr,
    output logic [`HBIT_DATA:0] ow_mem_wdata,
    input  logic [`HBIT_DATA:0] iw_mem_rdata,
`ifdef MEM_ARB_STATS_EN
    input  logic                iw_stats_clr,
    output logic [15:0]         or_gnt_cnt   [0:NREQ-1],
    output logic [7:0]          or_wait_max,
`endif
    output logic                or_locked
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
    localparam logic [IW-1:0] LastInit = IW'(NREQ - 1);

    typedef enum logic {StArb, StLocked} state_t;

    state_t        state;
    logic [IW-1:0] r_last;
    logic [IW-1:0] owner;
    logic [CW-1:0] lock_cnt;

    logic          any_gnt;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          lock_expire;

    // Scan downwards so the candidate closest after r_last is the last one written.
    always_comb begin
        any_gnt = 1'b0;
        win     = '0;
        cand    = '0;
        if (state == StLocked) begin
            any_gnt = iw_req[owner];
            win     = owner;
        end else begin
            for (int unsigned k = NREQ; k >= 1; k--) begin
                cand = IW'((32'(r_last) + k) % NREQ);
                if (iw_req[cand]) begin
                    any_gnt = 1'b1;
                    win     = cand;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            ow_gnt[i] = any_gnt && (win == IW'(i));
        end
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (any_gnt) begin
            ow_mem_we    = iw_we[win];
            ow_mem_addr  = iw_addr[win];
            ow_mem_wdata = iw_wdata[win];
        end
    end

    assign ow_rdata    = iw_mem_rdata;
    assign lock_expire = (LOCK_MAX != 0) && ((32'(lock_cnt) + 32'd1) >= LOCK_MAX);

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state     <= StArb;
            r_last    <= LastInit;
            owner     <= '0;
            lock_cnt  <= '0;
            or_locked <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                or_rvalid[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                or_rvalid[i] <= ow_gnt[i] && !iw_we[i];
            end
            // While locked only the owner is granted, so r_last ends up as the owner on release.
            if (any_gnt) begin
                r_last <= win;
            end
            unique case (state)
                StArb: begin
                    // With LOCK_MAX of 1 the locking access already uses up the whole budget.
                    if (any_gnt && iw_lock[win] && (LOCK_MAX != 1)) begin
                        state     <= StLocked;
                        owner     <= win;
                        lock_cnt  <= CW'(1);
                        or_locked <= 1'b1;
                    end
                end
                StLocked: begin
                    if (lock_cnt != '1) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                    if (!iw_lock[owner] || lock_expire) begin
                        state     <= StArb;
                        lock_cnt  <= '0;
                        or_locked <= 1'b0;
                    end
                end
                default: begin
                    state     <= StArb;
                    or_locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [7:0] wait_cnt [0:NREQ-1];
    logic [7:0] wait_nxt [0:NREQ-1];
    logic [7:0] wait_max_d;

    always_comb begin
        wait_max_d = or_wait_max;
        for (int unsigned i = 0; i < NREQ; i++) begin
            wait_nxt[i] = '0;
            if (iw_req[i] && !ow_gnt[i]) begin
                wait_nxt[i] = (wait_cnt[i] == 8'hFF) ? 8'hFF : wait_cnt[i] + 8'd1;
            end
            if (wait_nxt[i] > wait_max_d) begin
                wait_max_d = wait_nxt[i];
            end
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst || iw_stats_clr) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                or_gnt_cnt[i] <= '0;
                wait_cnt[i]   <= '0;
            end
            or_wait_max <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                wait_cnt[i] <= wait_nxt[i];
                if (ow_gnt[i] && (or_gnt_cnt[i] != 16'hFFFF)) begin
                    or_gnt_cnt[i] <= or_gnt_cnt[i] + 16'd1;
                end
            end
            or_wait_max <= wait_max_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios then random traffic, all checked against a
// cycle-level reference model of the arbitration, lock and read-return rules.
`ifndef HBIT_ADDR
`define HBIT_ADDR 11
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

module tb_mem_port_arb;
    localparam int unsigned NREQ     = 3;
    localparam int          LOCK_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                req       [0:NREQ-1];
    logic                we        [0:NREQ-1];
    logic                lock      [0:NREQ-1];
    logic [`HBIT_ADDR:0] addr      [0:NREQ-1];
    logic [`HBIT_DATA:0] wdata     [0:NREQ-1];
    logic                gnt       [0:NREQ-1];
    logic                rvalid    [0:NREQ-1];
    logic [`HBIT_DATA:0] rdata;
    logic                mem_we;
    logic [`HBIT_ADDR:0] mem_addr;
    logic [`HBIT_DATA:0] mem_wdata;
    logic [`HBIT_DATA:0] mem_rdata;
    logic                locked;
`ifdef MEM_ARB_STATS_EN
    logic                stats_clr;
    logic [15:0]         gnt_cnt   [0:NREQ-1];
    logic [7:0]          wait_max;
`endif

    mem_port_arb #(
        .NREQ     (NREQ),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .iw_clk       (clk),
        .iw_rst       (rst),
        .iw_req       (req),
        .iw_we        (we),
        .iw_lock      (lock),
        .iw_addr      (addr),
        .iw_wdata     (wdata),
        .ow_gnt       (gnt),
        .or_rvalid    (rvalid),
        .ow_rdata     (rdata),
        .ow_mem_we    (mem_we),
        .ow_mem_addr  (mem_addr),
        .ow_mem_wdata (mem_wdata),
        .iw_mem_rdata (mem_rdata),
`ifdef MEM_ARB_STATS_EN
        .iw_stats_clr (stats_clr),
        .or_gnt_cnt   (gnt_cnt),
        .or_wait_max  (wait_max),
`endif
        .or_locked    (locked)
    );

    // Memory behind the port: registered read, write visible to the next cycle's read.
    bit [23:0] env_mem [0:63];
    always @(posedge clk) begin
        mem_rdata <= env_mem[mem_addr[5:0]];
        if (mem_we) env_mem[mem_addr[5:0]] <= mem_wdata;
    end

    // Reference model state
    int            m_last;
    int            m_owner;
    int            m_cnt;
    bit            m_locked;
    bit [NREQ-1:0] exp_rv;
    bit [23:0]     exp_rdata;
    bit [23:0]     ref_mem [0:63];
    int            cur_g;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gnt_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NREQ; i++) v[i] = gnt[i];
        return v;
    endfunction

    function automatic logic [31:0] rv_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NREQ; i++) v[i] = rvalid[i];
        return v;
    endfunction

    // Owner only while locked; otherwise first requester after the last winner, cyclically.
    function automatic int model_gnt();
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 1; k <= NREQ; k++) begin
            int c = (m_last + k) % NREQ;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last   = NREQ - 1;
        m_owner  = 0;
        m_cnt    = 0;
        m_locked = 1'b0;
        exp_rv   = '0;
    endtask

    task automatic set_req(input int i, input bit r, input bit w, input bit l,
                           input logic [`HBIT_ADDR:0] a, input logic [`HBIT_DATA:0] d);
        req[i]   = r;
        we[i]    = w;
        lock[i]  = l;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    task automatic idle();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic settle();
        #4;
        cur_g = model_gnt();
        chk("gnt", gnt_vec(), (cur_g < 0) ? 32'd0 : (32'd1 << cur_g));
        if (cur_g >= 0) begin
            chk("mem_we", 32'(mem_we), 32'(we[cur_g]));
            chk("mem_addr", 32'(mem_addr), 32'(addr[cur_g]));
            chk("mem_wdata", 32'(mem_wdata), 32'(wdata[cur_g]));
        end else begin
            chk("mem_idle", {7'd0, mem_we, 12'(mem_addr), 12'(mem_wdata)}, 32'd0);
            chk("mem_idle_wdata", 32'(mem_wdata), 32'd0);
        end
        chk("rvalid", rv_vec(), 32'(exp_rv));
        chk("locked", 32'(locked), 32'(m_locked));
        if (exp_rv != '0) chk("rdata", 32'(rdata), 32'(exp_rdata));
    endtask

    task automatic advance();
        if (rst) begin
            model_reset();
        end else begin
            exp_rv = '0;
            if (cur_g >= 0) begin
                if (we[cur_g]) begin
                    ref_mem[addr[cur_g][5:0]] = wdata[cur_g];
                end else begin
                    exp_rv[cur_g] = 1'b1;
                    exp_rdata     = ref_mem[addr[cur_g][5:0]];
                end
                m_last = cur_g;
            end
            if (!m_locked) begin
                if (cur_g >= 0 && lock[cur_g] && LOCK_MAX != 1) begin
                    m_locked = 1'b1;
                    m_owner  = cur_g;
                    m_cnt    = 1;
                end
            end else begin
                m_cnt++;
                if (!lock[m_owner] || (LOCK_MAX != 0 && m_cnt >= LOCK_MAX)) m_locked = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        idle();
        rst = 1'b1;
`ifdef MEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        cyc();

        // 1: all three read continuously -> 0,1,2,0,1,2 with rvalid one cycle behind
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, 12'(16 * i + k), '0);
            settle();
            chk("t1_order", gnt_vec(), 32'd1 << (k % 3));
            if (k > 0) chk("t1_rvalid", rv_vec(), 32'd1 << ((k - 1) % 3));
            advance();
        end

        // 2: write then read of the same address from another requester
        idle();
        set_req(1, 1'b1, 1'b1, 1'b0, 12'h010, 24'hABCDEF);
        cyc();
        idle();
        set_req(2, 1'b1, 1'b0, 1'b0, 12'h010, '0);
        settle();
        chk("t2_gnt2", 32'(gnt[2]), 32'd1);
        advance();
        idle();
        settle();
        chk("t2_rvalid", rv_vec(), 32'b100);
        chk("t2_rdata", 32'(rdata), 32'h00ABCDEF);
        advance();

        // 3: locked read-modify-write by req0 holds off req1 for three cycles
        set_req(0, 1'b1, 1'b0, 1'b1, 12'h020, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h030, '0);
        settle();
        chk("t3_c1_gnt0", 32'(gnt[0]), 32'd1);
        chk("t3_c1_gnt1", 32'(gnt[1]), 32'd0);
        advance();
        set_req(0, 1'b1, 1'b1, 1'b1, 12'h020, 24'h111111);
        settle();
        chk("t3_c2_gnt1", 32'(gnt[1]), 32'd0);
        chk("t3_c2_locked", 32'(locked), 32'd1);
        advance();
        set_req(0, 1'b1, 1'b1, 1'b0, 12'h021, 24'h222222);
        settle();
        chk("t3_c3_gnt1", 32'(gnt[1]), 32'd0);
        chk("t3_c3_locked", 32'(locked), 32'd1);
        advance();
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        settle();
        chk("t3_c4_gnt1", 32'(gnt[1]), 32'd1);
        chk("t3_c4_locked", 32'(locked), 32'd0);
        advance();
        idle();
        set_req(2, 1'b1, 1'b0, 1'b0, 12'h021, '0);
        cyc();

        // 4: lock held forever is cut off after LOCK_MAX owner cycles
        idle();
        set_req(2, 1'b1, 1'b0, 1'b0, 12'h008, '0);
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 1'b0, 1'b1, 12'(k), '0);
            settle();
            chk("t4_owner", 32'(gnt[0]), 32'd1);
            chk("t4_gnt2", 32'(gnt[2]), 32'd0);
            advance();
        end
        settle();
        chk("t4_release_gnt2", 32'(gnt[2]), 32'd1);
        chk("t4_release_locked", 32'(locked), 32'd0);
        advance();
        idle();

        // 5: reset the cycle after a locked read grant
        set_req(0, 1'b1, 1'b0, 1'b1, 12'h00C, '0);
        settle();
        chk("t5_gnt0", 32'(gnt[0]), 32'd1);
        advance();
        rst = 1'b1;
        settle();
        chk("t5_locked_pre", 32'(locked), 32'd1);
        advance();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, 12'h00C, '0);
        settle();
        chk("t5_rvalid", rv_vec(), 32'd0);
        chk("t5_locked", 32'(locked), 32'd0);
        chk("t5_gnt0", gnt_vec(), 32'd1);
        advance();
        idle();
        cyc();

`ifdef MEM_ARB_STATS_EN
        // 6: grant counters over 30 fully contended cycles, then clear
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, 12'(k), '0);
            cyc();
        end
        idle();
        settle();
        for (int i = 0; i < NREQ; i++) chk("t6_gnt_cnt", 32'(gnt_cnt[i]), 32'd10);
        chk("t6_wait_max", 32'(wait_max), 32'd2);
        advance();
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        settle();
        for (int i = 0; i < NREQ; i++) chk("t6_clr_cnt", 32'(gnt_cnt[i]), 32'd0);
        chk("t6_clr_wait", 32'(wait_max), 32'd0);
        advance();
`endif

        // Random traffic: each requester holds its access until granted, then draws a new one
        idle();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || cur_g == i) begin
                    set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                            $urandom_range(0, 3) == 0, 12'($urandom_range(0, 15)),
                            24'($urandom));
                end
            end
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
